ula_pipe: RTL and testbench

ULA_PIPE -- requirements
Module: ula_pipe

---
 rtl/ula_pkg.sv | 31 +++
 rtl/ula_mul_iter.sv | 67 ++++++
 rtl/ula_pipe.sv | 162 ++++++++++++++++
 tb/tb_ula_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared types for the ula_pipe ALU.
//   ULA_OP_W     opcode width
//   ula_op_e     opcode encoding (ULA_ADD .. ULA_MUL)
//   ula_state_e  control states; ST_MUL exists only when ULA_PIPE_MUL_EN is defined
package ula_pkg;

  localparam int unsigned ULA_OP_W = 3;

  typedef enum logic [ULA_OP_W-1:0] {
    ULA_ADD = 3'b000,
    ULA_SUB = 3'b001,
    ULA_AND = 3'b010,
    ULA_OR  = 3'b011,
    ULA_XOR = 3'b100,
    ULA_NOT = 3'b101,
    ULA_SLL = 3'b110,
    ULA_MUL = 3'b111
  } ula_op_e;

`ifdef ULA_PIPE_MUL_EN
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ula_state_e;
`else
  typedef enum logic {
    ST_IDLE = 1'b0
  } ula_state_e;
`endif

endpackage

// File: rtl/ula_mul_iter.sv
// ula_mul_iter: iterative shift-add multiplier, low WIDTH bits of a*b (unsigned).
// Built into ula_pipe only when ULA_PIPE_MUL_EN is defined.
//   clk_i, rst_n_i  clock, async active-low reset
//   start_i         load operands (ignored while busy_o=1)
//   a_i, b_i        operands
//   busy_o          registered, high while stepping
//   done_o          combinational: the step on the coming edge is the last one
//   product_o       value the accumulator takes on the coming edge; final
//                   product when done_o=1
module ula_mul_iter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_step;

  // done/product are exposed one step early so the parent can register the
  // result on the WIDTH-th edge after the loading edge.
  assign w_step    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign busy_o    = r_busy;
  assign done_o    = r_busy && (r_cnt == LAST);
  assign product_o = w_step;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (!r_busy) begin
      if (start_i) begin
        r_mcand  <= a_i;
        r_mplier <= b_i;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
    end else begin
      r_acc    <= w_step;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_pipe.sv
// ula_pipe: single-issue ALU with registered result and Z/N/C/V flags.
// Macro ULA_PIPE_MUL_EN enables opcode 111 as a WIDTH-cycle iterative multiply;
// without it opcode 111 completes in one cycle with result 0.
//   clk_i, rst_n_i            clock, async active-low reset
//   start_i, op_i             request and opcode (sampled while busy_o=0)
//   operand1_i, operand2_i    operands
//   busy_o                    multiply in progress
//   done_o                    one-cycle pulse: new result_o/flags
//   result_o, z_o,n_o,c_o,v_o registered result and flags
module ula_pipe
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 11
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [ULA_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    operand1_i,
  input  logic [WIDTH-1:0]    operand2_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    result_o,
  output logic                z_o,
  output logic                n_o,
  output logic                c_o,
  output logic                v_o
);

  ula_op_e          w_op;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH-1:0] w_fin_res;
  logic             w_fin_c;
  logic             w_fin_v;
  logic             w_capture;

  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  assign w_op = ula_op_e'(op_i);

  // SUB reuses the adder as op1 + ~op2 + 1, so carry=1 means no borrow.
  always_comb begin
    w_b_eff = (w_op == ULA_SUB) ? ~operand2_i : operand2_i;
    w_cin   = (w_op == ULA_SUB);
    w_sum   = {1'b0, operand1_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (w_op)
      ULA_ADD, ULA_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (operand1_i[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != operand1_i[WIDTH-1]);
      end
      ULA_AND: w_alu_res = operand1_i & operand2_i;
      ULA_OR:  w_alu_res = operand1_i | operand2_i;
      ULA_XOR: w_alu_res = operand1_i ^ operand2_i;
      ULA_NOT: w_alu_res = ~operand1_i;
      ULA_SLL: begin
        w_alu_res = {operand1_i[WIDTH-2:0], 1'b0};
        w_alu_c   = operand1_i[WIDTH-1];
      end
      default: w_alu_res = '0;
    endcase
  end

`ifdef ULA_PIPE_MUL_EN
  ula_state_e       r_state;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  assign w_mul_start = (r_state == ST_IDLE) && start_i && (w_op == ULA_MUL);

  ula_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (w_mul_start),
    .a_i      (operand1_i),
    .b_i      (operand2_i),
    .busy_o   (w_mul_busy),
    .done_o   (w_mul_done),
    .product_o(w_mul_prod)
  );

  // While in ST_MUL the op/operand inputs are don't-care; the result comes
  // from the multiplier and C/V are forced low.
  always_comb begin
    w_capture = ((r_state == ST_IDLE) && start_i && (w_op != ULA_MUL)) ||
                ((r_state == ST_MUL) && w_mul_done);
    w_fin_res = (r_state == ST_MUL) ? w_mul_prod : w_alu_res;
    w_fin_c   = (r_state == ST_MUL) ? 1'b0 : w_alu_c;
    w_fin_v   = (r_state == ST_MUL) ? 1'b0 : w_alu_v;
  end

  assign busy_o = w_mul_busy;
`else
  always_comb begin
    w_capture = start_i;
    w_fin_res = w_alu_res;
    w_fin_c   = w_alu_c;
    w_fin_v   = w_alu_v;
  end

  assign busy_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
`ifdef ULA_PIPE_MUL_EN
      r_state  <= ST_IDLE;
`endif
      r_result <= '0;
      r_done   <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
`ifdef ULA_PIPE_MUL_EN
      case (r_state)
        ST_IDLE: if (w_mul_start) r_state <= ST_MUL;
        ST_MUL:  if (w_mul_done)  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
`endif
      r_done <= w_capture;
      if (w_capture) begin
        r_result <= w_fin_res;
        r_z      <= (w_fin_res == '0);
        r_n      <= w_fin_res[WIDTH-1];
        r_c      <= w_fin_c;
        r_v      <= w_fin_v;
      end
    end
  end

  assign result_o = r_result;
  assign done_o   = r_done;
  assign z_o      = r_z;
  assign n_o      = r_n;
  assign c_o      = r_c;
  assign v_o      = r_v;

endmodule

// File: tb/tb_ula_pipe.sv
// tb_ula_pipe: scoreboard bench for ula_pipe at WIDTH=11. The multiply tests
// follow ULA_PIPE_MUL_EN so the bench matches whichever build it is compiled with.
module tb_ula_pipe;

  localparam int unsigned W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, z, n, c, v;
  logic [W-1:0] result;
  logic [W+3:0] got;

  ula_pipe #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .op_i      (op),
    .operand1_i(a),
    .operand2_i(b),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .z_o       (z),
    .n_o       (n),
    .c_o       (c),
    .v_o       (v)
  );

  always #5 clk = ~clk;

  assign got = {result, z, n, c, v};

  logic [W+3:0] sb_q[$];
  logic [W+3:0] exp_v;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+3:0] e;   // {result, z, n, c, v}
  } vec_t;

  vec_t tbl[12] = '{
    '{3'd0, 11'h003, 11'h002, {11'h005, 4'b0000}},  // ADD 3+2
    '{3'd1, 11'h003, 11'h002, {11'h001, 4'b0010}},  // SUB 3-2, no borrow
    '{3'd1, 11'h002, 11'h003, {11'h7FF, 4'b0100}},  // SUB 2-3, borrow
    '{3'd1, 11'h003, 11'h003, {11'h000, 4'b1010}},  // SUB 3-3
    '{3'd0, 11'h3FF, 11'h001, {11'h400, 4'b0101}},  // ADD signed overflow
    '{3'd0, 11'h7FF, 11'h001, {11'h000, 4'b1010}},  // ADD wrap with carry
    '{3'd2, 11'h5A5, 11'h0FF, {11'h0A5, 4'b0000}},  // AND
    '{3'd3, 11'h400, 11'h001, {11'h401, 4'b0100}},  // OR
    '{3'd4, 11'h7FF, 11'h7FF, {11'h000, 4'b1000}},  // XOR
    '{3'd5, 11'h000, 11'h123, {11'h7FF, 4'b0100}},  // NOT
    '{3'd6, 11'h401, 11'h000, {11'h002, 4'b0010}},  // SLL carry out
    '{3'd6, 11'h200, 11'h000, {11'h400, 4'b0100}}   // SLL into sign bit
  };

  // Reference model with plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [2:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint m  = longint'(1) << W;
    longint ua = longint'(x);
    longint ub = longint'(y);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint s, t, r;
    logic cc, vv;
    r = 0; cc = 1'b0; vv = 1'b0;
    case (o)
      3'd0: begin
        s = ua + ub; r = s % m; cc = (s >= m);
        t = sa + sb; vv = (t >= m / 2) || (t < -(m / 2));
      end
      3'd1: begin
        s = ua + (m - 1 - ub) + 1; r = s % m; cc = (s >= m);
        t = sa - sb; vv = (t >= m / 2) || (t < -(m / 2));
      end
      3'd2: r = longint'(x & y);
      3'd3: r = longint'(x | y);
      3'd4: r = longint'(x ^ y);
      3'd5: r = m - 1 - ua;
      3'd6: begin r = (ua * 2) % m; cc = (ua >= m / 2); end
      default: begin
`ifdef ULA_PIPE_MUL_EN
        r = (ua * ub) % m;
`else
        r = 0;
`endif
      end
    endcase
    return {r[W-1:0], (r == 0), (r >= m / 2), cc, vv};
  endfunction

  task automatic drive(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W+3:0] e);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(e);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", got);
    end
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_busy_done got %b want 00", {busy, done});
    end
    rst_n = 1'b1;
  endtask

  // Isolated ops: latency 1, single-cycle done pulse, result held afterwards.
  task automatic test_alu;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      @(negedge clk);
      start = 1'b0;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (done !== 1'b1 || got !== exp_v) begin
        n_err++;
        $display("FAIL alu[%0d] done=%b got %h want done=1 %h", i, done, got, exp_v);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || got !== exp_v) begin
        n_err++;
        $display("FAIL alu_hold[%0d] done=%b got %h want done=0 %h", i, done, got, exp_v);
      end
    end
  endtask

  // start held high: a result every cycle.
  task automatic test_back_to_back;
    logic [2:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = sb_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || got !== exp_v) begin
          n_err++;
          $display("FAIL b2b[%0d] done=%b got %h want done=1 %h", i - 1, done, got, exp_v);
        end
      end
      if (i < 30) begin
`ifdef ULA_PIPE_MUL_EN
        o = 3'($urandom_range(0, 6));
`else
        o = 3'($urandom_range(0, 7));
`endif
        x = W'($urandom_range(0, 2047));
        y = W'($urandom_range(0, 2047));
        drive(o, x, y, model(o, x, y));
      end else begin
        start = 1'b0;
      end
    end
  endtask

`ifdef ULA_PIPE_MUL_EN
  task automatic test_mul;
    logic [W-1:0] ma[3] = '{11'd13, 11'h7FF, 11'd100};
    logic [W-1:0] mb[3] = '{11'd7, 11'h7FF, 11'd50};
    logic [W+3:0] me[3] = '{{11'd91, 4'b0000}, {11'h001, 4'b0000}, {11'h388, 4'b0000}};
    int k;
    bit seen;
    int busy_gaps;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(3'd7, ma[j], mb[j], me[j]);
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++; $display("FAIL mul_busy[%0d] busy=%b done=%b want 1 0", j, busy, done);
      end
      k = 0; seen = 1'b0; busy_gaps = 0;
      while (!seen && k < 40) begin
        // one ADD request mid-multiply must be ignored
        start = (k == 3); op = 3'd0; a = 11'd3; b = 11'd2;
        @(negedge clk);
        k++;
        if (done === 1'b1) seen = 1'b1;
        else if (busy !== 1'b1) busy_gaps++;
      end
      start = 1'b0;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (k != 11 || busy_gaps != 0) begin
        n_err++;
        $display("FAIL mul_latency[%0d] edges=%0d busy_gaps=%0d want 11 0", j, k, busy_gaps);
      end
      n_vec++;
      if (got !== exp_v || busy !== 1'b0) begin
        n_err++; $display("FAIL mul_result[%0d] got %h busy=%b want %h busy=0", j, got, busy, exp_v);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || got !== exp_v) begin
        n_err++; $display("FAIL mul_no_extra[%0d] done=%b got %h want 0 %h", j, done, got, exp_v);
      end
    end
  endtask
`else
  task automatic test_mul_off;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      drive(3'd7, (j == 0) ? 11'd13 : 11'h7FF, (j == 0) ? 11'd7 : 11'h7FF, {11'd0, 4'b1000});
      @(negedge clk);
      start = 1'b0;
      exp_v = sb_q.pop_front();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || got !== exp_v) begin
        n_err++;
        $display("FAIL mul_off[%0d] done=%b busy=%b got %h want 1 0 %h", j, done, busy, got, exp_v);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL mul_off_after[%0d] done=%b busy=%b want 0 0", j, done, busy);
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    int extra;
`ifdef ULA_PIPE_MUL_EN
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 11'd13; b = 11'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
`else
    @(negedge clk);
    drive(3'd0, 11'd5, 11'd6, {11'd11, 4'b0000});
    @(negedge clk);
    start = 1'b0;
    exp_v = sb_q.pop_front();
    n_vec++;
    if (done !== 1'b1 || got !== exp_v) begin
      n_err++; $display("FAIL pre_reset got %h want %h", got, exp_v);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (got !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL async_reset got %h busy=%b done=%b want 0", got, busy, done);
    end
    repeat (2) @(negedge clk);
    // release and request on the same cycle: first edge must take the ADD
    rst_n = 1'b1;
    drive(3'd0, 11'd1, 11'd1, {11'd2, 4'b0000});
    @(negedge clk);
    start = 1'b0;
    exp_v = sb_q.pop_front();
    n_vec++;
    if (done !== 1'b1 || got !== exp_v) begin
      n_err++; $display("FAIL post_reset_add done=%b got %h want 1 %h", done, got, exp_v);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL no_done_after_abort got %0d stray cycles want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
`ifdef ULA_PIPE_MUL_EN
    test_mul();
`else
    test_mul_off();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
